ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg_if.sv | 49 ++++
 rtl/ex_mem_reg.sv | 138 +++++++++++++
 tb/tb_ex_mem_reg.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline register bundle: stage controls, EX-side capture inputs,
// MEM-side registered outputs and the combinational forwarding tap.
interface ex_mem_reg_if;
    logic        i_stall;
    logic        i_flush;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_alu_result;
    logic [31:0] i_ex_rs2_data;
    logic [4:0]  i_ex_rd_addr;
    logic        i_ex_rd_wren;
    logic        i_ex_mem_wren;
    logic        i_ex_mem_rden;
    logic [2:0]  i_ex_funct3;
    logic [1:0]  i_ex_wb_sel;

    logic        o_mem_valid;
    logic [31:0] o_mem_pc;
    logic [31:0] o_mem_alu_result;
    logic [31:0] o_mem_store_data;
    logic [3:0]  o_mem_bmask;
    logic [4:0]  o_mem_rd_addr;
    logic        o_mem_rd_wren;
    logic        o_mem_mem_wren;
    logic        o_mem_mem_rden;
    logic [2:0]  o_mem_funct3;
    logic [1:0]  o_mem_wb_sel;
    logic        o_mem_misaligned;

    logic        o_fwd_en;
    logic [4:0]  o_fwd_rd_addr;
    logic [31:0] o_fwd_data;

    modport slave (
        input  i_stall, i_flush, i_ex_valid, i_ex_pc, i_ex_alu_result, i_ex_rs2_data,
               i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_wren, i_ex_mem_rden, i_ex_funct3, i_ex_wb_sel,
        output o_mem_valid, o_mem_pc, o_mem_alu_result, o_mem_store_data, o_mem_bmask,
               o_mem_rd_addr, o_mem_rd_wren, o_mem_mem_wren, o_mem_mem_rden, o_mem_funct3,
               o_mem_wb_sel, o_mem_misaligned, o_fwd_en, o_fwd_rd_addr, o_fwd_data
    );

    modport master (
        output i_stall, i_flush, i_ex_valid, i_ex_pc, i_ex_alu_result, i_ex_rs2_data,
               i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_wren, i_ex_mem_rden, i_ex_funct3, i_ex_wb_sel,
        input  o_mem_valid, o_mem_pc, o_mem_alu_result, o_mem_store_data, o_mem_bmask,
               o_mem_rd_addr, o_mem_rd_wren, o_mem_mem_wren, o_mem_mem_rden, o_mem_funct3,
               o_mem_wb_sel, o_mem_misaligned, o_fwd_en, o_fwd_rd_addr, o_fwd_data
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the EX result, lane-aligns store data,
// flags misaligned accesses and exposes the MEM-stage forwarding tap.
module ex_mem_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ex_mem_reg_if.slave   bus
);

    // One-hot access size {word, half, byte}; zero marks an illegal funct3.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            3'b000, 3'b100: size = 3'b001;
            3'b001, 3'b101: size = 3'b010;
            3'b010:         size = 3'b100;
            default:        size = 3'b000;
        endcase
        return size;
    endfunction

    logic [2:0]  size_s;
    logic        access_s;
    logic        align_fault_s;
    logic        misaligned_s;
    logic [31:0] store_data_s;
    logic [3:0]  lane_mask_s;

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] alu_result_r;
    logic [31:0] store_data_r;
    logic [3:0]  bmask_r;
    logic [4:0]  rd_addr_r;
    logic        rd_wren_r;
    logic        mem_wren_r;
    logic        mem_rden_r;
    logic [2:0]  funct3_r;
    logic [1:0]  wb_sel_r;
    logic        misaligned_r;

    // Derive alignment, store-lane replication and byte mask from the EX operands.
    always_comb begin
        size_s        = access_size(bus.i_ex_funct3);
        access_s      = bus.i_ex_valid & (bus.i_ex_mem_wren | bus.i_ex_mem_rden);
        align_fault_s = 1'b0;
        store_data_s  = bus.i_ex_rs2_data;
        lane_mask_s   = 4'b0000;
        case (size_s)
            3'b001: begin
                align_fault_s = 1'b0;
                store_data_s  = {4{bus.i_ex_rs2_data[7:0]}};
                lane_mask_s   = 4'b0001 << bus.i_ex_alu_result[1:0];
            end
            3'b010: begin
                align_fault_s = bus.i_ex_alu_result[0];
                store_data_s  = {2{bus.i_ex_rs2_data[15:0]}};
                lane_mask_s   = 4'b0011 << bus.i_ex_alu_result[1:0];
            end
            3'b100: begin
                align_fault_s = |bus.i_ex_alu_result[1:0];
                store_data_s  = bus.i_ex_rs2_data;
                lane_mask_s   = 4'b1111;
            end
            default: begin
                align_fault_s = 1'b1;
                store_data_s  = bus.i_ex_rs2_data;
                lane_mask_s   = 4'b0000;
            end
        endcase
        misaligned_s = access_s & align_fault_s;
    end

    // Pipeline register: reset > flush > stall(hold) > load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r      <= 1'b0;
            pc_r         <= PC_RESET;
            alu_result_r <= 32'h0000_0000;
            store_data_r <= 32'h0000_0000;
            bmask_r      <= 4'b0000;
            rd_addr_r    <= 5'd0;
            rd_wren_r    <= 1'b0;
            mem_wren_r   <= 1'b0;
            mem_rden_r   <= 1'b0;
            funct3_r     <= 3'b000;
            wb_sel_r     <= 2'b00;
            misaligned_r <= 1'b0;
        end else if (bus.i_flush) begin
            valid_r      <= 1'b0;
            pc_r         <= PC_RESET;
            alu_result_r <= 32'h0000_0000;
            store_data_r <= 32'h0000_0000;
            bmask_r      <= 4'b0000;
            rd_addr_r    <= 5'd0;
            rd_wren_r    <= 1'b0;
            mem_wren_r   <= 1'b0;
            mem_rden_r   <= 1'b0;
            funct3_r     <= 3'b000;
            wb_sel_r     <= 2'b00;
            misaligned_r <= 1'b0;
        end else if (!bus.i_stall) begin
            valid_r      <= bus.i_ex_valid;
            pc_r         <= bus.i_ex_pc;
            alu_result_r <= bus.i_ex_alu_result;
            store_data_r <= store_data_s;
            rd_addr_r    <= bus.i_ex_rd_addr;
            funct3_r     <= bus.i_ex_funct3;
            wb_sel_r     <= bus.i_ex_wb_sel;
            misaligned_r <= misaligned_s;
            // A misaligned access is kept valid but stripped of all side effects.
            rd_wren_r    <= bus.i_ex_valid & bus.i_ex_rd_wren & (bus.i_ex_rd_addr != 5'd0) & ~misaligned_s;
            mem_wren_r   <= bus.i_ex_valid & bus.i_ex_mem_wren & ~misaligned_s;
            mem_rden_r   <= bus.i_ex_valid & bus.i_ex_mem_rden & ~misaligned_s;
            bmask_r      <= (bus.i_ex_valid & bus.i_ex_mem_wren & ~misaligned_s) ? lane_mask_s : 4'b0000;
        end
    end

    assign bus.o_mem_valid      = valid_r;
    assign bus.o_mem_pc         = pc_r;
    assign bus.o_mem_alu_result = alu_result_r;
    assign bus.o_mem_store_data = store_data_r;
    assign bus.o_mem_bmask      = bmask_r;
    assign bus.o_mem_rd_addr    = rd_addr_r;
    assign bus.o_mem_rd_wren    = rd_wren_r;
    assign bus.o_mem_mem_wren   = mem_wren_r;
    assign bus.o_mem_mem_rden   = mem_rden_r;
    assign bus.o_mem_funct3     = funct3_r;
    assign bus.o_mem_wb_sel     = wb_sel_r;
    assign bus.o_mem_misaligned = misaligned_r;

    // Loads cannot forward from MEM: their data is not available until WB.
    assign bus.o_fwd_en      = valid_r & rd_wren_r & ~mem_rden_r;
    assign bus.o_fwd_rd_addr = rd_addr_r;
    assign bus.o_fwd_data    = alu_result_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a behavioural model of
// the EX/MEM register rules.
module tb_ex_mem_reg;

    localparam logic [31:0] PC_RST = 32'hA5A5_0100;

    logic i_clk;
    logic i_rst_n;
    ex_mem_reg_if bus();

    ex_mem_reg #(.PC_RESET(PC_RST)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [3:0]  bmask;
        logic [4:0]  rd;
        logic        rdw;
        logic        mw;
        logic        mr;
        logic [2:0]  f3;
        logic [1:0]  wb;
        logic        mis;
    } mem_state_t;

    mem_state_t exp_st;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mem_state_t cleared();
        mem_state_t s;
        s.valid = 1'b0; s.pc = PC_RST; s.alu = 32'h0; s.sdata = 32'h0; s.bmask = 4'h0;
        s.rd = 5'd0; s.rdw = 1'b0; s.mw = 1'b0; s.mr = 1'b0; s.f3 = 3'd0; s.wb = 2'd0; s.mis = 1'b0;
        return s;
    endfunction

    // Model of a normal load, expressed in access bytes and address arithmetic.
    function automatic mem_state_t loaded();
        mem_state_t s;
        int nbytes;
        int offs;
        logic acc;
        case (bus.i_ex_funct3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        offs    = int'(bus.i_ex_alu_result % 32'd4);
        acc     = bus.i_ex_valid && (bus.i_ex_mem_wren || bus.i_ex_mem_rden);
        s.mis   = acc && ((nbytes == 0) || ((offs % ((nbytes == 0) ? 1 : nbytes)) != 0));
        s.valid = bus.i_ex_valid;
        s.pc    = bus.i_ex_pc;
        s.alu   = bus.i_ex_alu_result;
        s.rd    = bus.i_ex_rd_addr;
        s.f3    = bus.i_ex_funct3;
        s.wb    = bus.i_ex_wb_sel;
        s.mw    = bus.i_ex_valid && bus.i_ex_mem_wren && !s.mis;
        s.mr    = bus.i_ex_valid && bus.i_ex_mem_rden && !s.mis;
        s.rdw   = bus.i_ex_valid && bus.i_ex_rd_wren && (bus.i_ex_rd_addr != 5'd0) && !s.mis;
        if (nbytes == 1)      s.sdata = (bus.i_ex_rs2_data & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 2) s.sdata = (bus.i_ex_rs2_data & 32'hFFFF) * 32'h0001_0001;
        else                  s.sdata = bus.i_ex_rs2_data;
        if (s.mw) s.bmask = 4'(((1 << nbytes) - 1) << offs);
        else      s.bmask = 4'h0;
        return s;
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, ".valid"}, 32'(bus.o_mem_valid),      32'(exp_st.valid));
        chk({ctx, ".pc"},    bus.o_mem_pc,              exp_st.pc);
        chk({ctx, ".alu"},   bus.o_mem_alu_result,      exp_st.alu);
        chk({ctx, ".sdata"}, bus.o_mem_store_data,      exp_st.sdata);
        chk({ctx, ".bmask"}, 32'(bus.o_mem_bmask),      32'(exp_st.bmask));
        chk({ctx, ".rd"},    32'(bus.o_mem_rd_addr),    32'(exp_st.rd));
        chk({ctx, ".rdw"},   32'(bus.o_mem_rd_wren),    32'(exp_st.rdw));
        chk({ctx, ".mw"},    32'(bus.o_mem_mem_wren),   32'(exp_st.mw));
        chk({ctx, ".mr"},    32'(bus.o_mem_mem_rden),   32'(exp_st.mr));
        chk({ctx, ".f3"},    32'(bus.o_mem_funct3),     32'(exp_st.f3));
        chk({ctx, ".wb"},    32'(bus.o_mem_wb_sel),     32'(exp_st.wb));
        chk({ctx, ".mis"},   32'(bus.o_mem_misaligned), 32'(exp_st.mis));
        chk({ctx, ".fwd_en"}, 32'(bus.o_fwd_en), 32'(exp_st.valid && exp_st.rdw && !exp_st.mr));
        chk({ctx, ".fwd_rd"}, 32'(bus.o_fwd_rd_addr), 32'(exp_st.rd));
        chk({ctx, ".fwd_d"},  bus.o_fwd_data, exp_st.alu);
    endtask

    // One clock: model update at the edge, then sample just after it.
    task automatic cycle(input string ctx);
        @(posedge i_clk);
        if (!i_rst_n)          exp_st = cleared();
        else if (bus.i_flush)  exp_st = cleared();
        else if (!bus.i_stall) exp_st = loaded();
        #1;
        check_all(ctx);
        @(negedge i_clk);
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic rdw,
                          input logic mw, input logic mr, input logic [2:0] f3, input logic [1:0] wb);
        bus.i_ex_valid = v;   bus.i_ex_pc = pc;   bus.i_ex_alu_result = alu;
        bus.i_ex_rs2_data = rs2; bus.i_ex_rd_addr = rd; bus.i_ex_rd_wren = rdw;
        bus.i_ex_mem_wren = mw; bus.i_ex_mem_rden = mr; bus.i_ex_funct3 = f3; bus.i_ex_wb_sel = wb;
    endtask

    task automatic set_rand();
        logic mem_op;
        mem_op = ($urandom_range(0, 2) != 0);
        set_ex(($urandom_range(0, 4) != 0), $urandom, $urandom, $urandom, 5'($urandom),
               1'($urandom), mem_op & 1'($urandom), mem_op & 1'($urandom), 3'($urandom), 2'($urandom));
    endtask

    initial begin
        i_rst_n = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_ex(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd9, 1'b1, 1'b0, 1'b0, 3'd2, 2'd1);
        exp_st = cleared();
        #12;
        check_all("reset");
        chk("reset.const_pc", bus.o_mem_pc, PC_RST);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // sra result forwarded from MEM
        set_ex(1'b1, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        cycle("sra");
        chk("sra.fwd_en_const", 32'(bus.o_fwd_en), 32'd1);
        chk("sra.fwd_d_const",  bus.o_fwd_data, 32'hFFFF_FFF0);

        // byte store to lane 3
        set_ex(1'b1, 32'h0000_0044, 32'h0000_1003, 32'h1234_56AB, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
        cycle("sb");
        chk("sb.sdata_const", bus.o_mem_store_data, 32'hABAB_ABAB);
        chk("sb.bmask_const", 32'(bus.o_mem_bmask), 32'h8);

        // misaligned word load
        set_ex(1'b1, 32'h0000_0048, 32'h0000_1002, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'd2, 2'd1);
        cycle("lw_mis");
        chk("lw_mis.mis_const", 32'(bus.o_mem_misaligned), 32'd1);
        chk("lw_mis.valid_const", 32'(bus.o_mem_valid), 32'd1);

        // rd=0 write, then an aligned load to rd=7
        set_ex(1'b1, 32'h0000_004C, 32'h0000_0123, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        cycle("rd0");
        set_ex(1'b1, 32'h0000_0050, 32'h0000_1000, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'd2, 2'd1);
        cycle("lw7");
        chk("lw7.fwd_en_const", 32'(bus.o_fwd_en), 32'd0);

        // three stalled cycles with changing inputs, then stall+flush
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_rand();
            cycle("stall");
        end
        bus.i_flush = 1'b1;
        set_rand();
        cycle("stall_flush");
        chk("stall_flush.pc_const", bus.o_mem_pc, PC_RST);
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;

        // randomized traffic with occasional stall/flush
        for (int n = 0; n < 300; n++) begin
            bus.i_stall = ($urandom_range(0, 4) == 0);
            bus.i_flush = ($urandom_range(0, 9) == 0);
            set_rand();
            cycle("rand");
        end

        // async reset between edges while stalled, then normal first load
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_ex(1'b1, 32'h0000_0080, 32'h0000_2000, 32'hCAFE_BEEF, 5'd3, 1'b1, 1'b1, 1'b0, 3'd1, 2'd2);
        cycle("pre_rst");
        bus.i_stall = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_st = cleared();
        check_all("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        bus.i_stall = 1'b0;
        set_ex(1'b1, 32'h0000_0090, 32'h0000_2002, 32'h0000_BEEF, 5'd4, 1'b1, 1'b1, 1'b0, 3'd5, 2'd3);
        cycle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
